// File: rtl/mult8u_pkg.sv
// mult8u_pkg: shared widths, default multiplier latency and sequencer states
package mult8u_pkg;
  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 16;
  localparam int DEF_MULT_LAT = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mult8u_lat_tag_pipe.sv
// mult8u_lat_tag_pipe: sync-reset valid-tag shift register matched to multiplier latency
module mult8u_lat_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_tag,
  output logic out_tag,
  output logic any_tag
);
  logic [DEPTH-1:0] tag;
  always_ff @(posedge clk)
    if (rst) tag <= '0;
    else tag <= (tag << 1) | DEPTH'(in_tag);
  assign out_tag = tag[DEPTH-1];
  assign any_tag = |tag;
endmodule

// File: rtl/mult8u_dot_seq.sv
// mult8u_dot_seq: streams operand pairs into the 8x8 multiplier and accumulates products into a dot product
module mult8u_dot_seq
  import mult8u_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 24,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  output logic [OPERAND_W-1:0] mult_multiplicand,
  output logic [OPERAND_W-1:0] mult_multiplier,
  input  logic [PRODUCT_W-1:0] mult_product,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     result,
  output logic                 ovf,
  output logic                 busy
);
  state_t st, nxt;
  logic [LEN_W-1:0] len_q, cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  logic fire, out_tag, any_tag;
  mult8u_lat_tag_pipe #(.DEPTH(MULT_LAT)) u_tags (
    .clk(clk), .rst(rst), .in_tag(fire), .out_tag(out_tag), .any_tag(any_tag)
  );
  always_comb begin
    in_ready = st == RUN;
    res_valid = st == DONE;
    busy = st != IDLE;
    fire = in_valid & in_ready;
    mult_multiplicand = fire ? in_a : '0;
    mult_multiplier = fire ? in_b : '0;
    result = res_valid ? acc : '0;
    sum = {1'b0, acc} + {{(ACC_W+1-PRODUCT_W){1'b0}}, mult_product};
    nxt = st;
    unique case (st)
      IDLE:  nxt = start ? ((len == '0) ? DONE : RUN) : IDLE;
      RUN:   nxt = (fire && cnt == len_q - 1'b1) ? DRAIN : RUN;
      DRAIN: nxt = any_tag ? DRAIN : DONE;
      DONE:  nxt = res_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      len_q <= '0;
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && start) begin
        len_q <= len;
        cnt <= '0;
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        if (fire) cnt <= cnt + 1'b1;
        if (out_tag) begin
          acc <= sum[ACC_W-1:0];
          if (sum[ACC_W]) ovf <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_mult8u_dot_seq.sv
// tb_mult8u_dot_seq: table-driven and directed checks of the dot-product sequencer with a 2-cycle multiplier model
module tb_mult8u_dot_seq;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, res_ready = 0;
  logic [7:0] len = 0, in_a = 0, in_b = 0;
  logic in_ready0, res_valid0, ovf0, busy0, in_ready1, res_valid1, ovf1, busy1;
  logic [7:0] ma0, mb0, ma1, mb1;
  logic [15:0] p1_0, p2_0, p1_1, p2_1;
  logic [23:0] result0;
  logic [16:0] result1;
  int errors = 0, checks = 0;
  logic [7:0] ta[256], tbv[256];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1_0 <= 16'(ma0) * 16'(mb0);
    p2_0 <= p1_0;
    p1_1 <= 16'(ma1) * 16'(mb1);
    p2_1 <= p1_1;
  end
  mult8u_dot_seq u0 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .mult_multiplicand(ma0), .mult_multiplier(mb0), .mult_product(p2_0),
    .res_valid(res_valid0), .res_ready(res_ready), .result(result0), .ovf(ovf0), .busy(busy0)
  );
  mult8u_dot_seq #(.ACC_W(17)) u1 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .mult_multiplicand(ma1), .mult_multiplier(mb1), .mult_product(p2_1),
    .res_valid(res_valid1), .res_ready(res_ready), .result(result1), .ovf(ovf1), .busy(busy1)
  );
  typedef struct {
    int n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    bit bub;
    int res;
    bit ov;
    int cyc;
  } vec_t;
  vec_t vt[6];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic job(input int n, input bit bub, output int cyc);
    int i;
    bit fired, bad;
    start = 1;
    len = 8'(n);
    tick();
    start = 0;
    cyc = 1;
    i = 0;
    bad = 0;
    while (i < n && cyc < 2000) begin
      if (!in_ready0) bad = 1;
      in_valid = !(bub && cyc % 2 == 0);
      in_a = ta[i];
      in_b = tbv[i];
      fired = in_valid && in_ready0;
      tick();
      cyc++;
      if (fired) i++;
    end
    in_valid = 0;
    in_a = 0;
    in_b = 0;
    chk("in_ready_after_last_fire", in_ready0, 0);
    chk("in_ready_during_run", bad, 0);
    while (!res_valid0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (cyc >= 2000) chk("job_timeout", cyc, 0);
  endtask
  task automatic consume();
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("idle_after_consume", {busy0, res_valid0, busy1}, 0);
  endtask
  initial begin
    int cyc;
    vt[0] = '{4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0, 70, 0, 8};
    vt[1] = '{4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1, 70, 0, 11};
    vt[2] = '{1, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd255}, 0, 65025, 0, 5};
    vt[3] = '{2, {8'd0, 8'd0, 8'd200, 8'd0}, {8'd0, 8'd0, 8'd3, 8'd9}, 0, 600, 0, 6};
    vt[4] = '{3, {8'd0, 8'd30, 8'd20, 8'd10}, {8'd0, 8'd3, 8'd2, 8'd1}, 0, 140, 0, 7};
    vt[5] = '{0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 0, 1};
    tick();
    tick();
    rst = 0;
    chk("reset_outputs", {in_ready0, res_valid0, ovf0, busy0}, 0);
    chk("reset_result", result0, 0);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        ta[k] = vt[i].a[k];
        tbv[k] = vt[i].b[k];
      end
      job(vt[i].n, vt[i].bub, cyc);
      chk($sformatf("vec%0d_result", i), result0, vt[i].res);
      chk($sformatf("vec%0d_ovf", i), ovf0, vt[i].ov);
      chk($sformatf("vec%0d_cycle", i), cyc, vt[i].cyc);
      for (int h = 0; h < 5; h++) begin
        start = vt[i].n == 0;
        len = 8'd4;
        tick();
        chk($sformatf("vec%0d_hold", i), {res_valid0, busy0, 24'(result0)}, {2'b11, 24'(vt[i].res)});
      end
      start = 0;
      consume();
    end
    for (int k = 0; k < 255; k++) begin
      ta[k] = 255;
      tbv[k] = 255;
    end
    job(255, 0, cyc);
    chk("max_result", result0, 16581375);
    chk("max_ovf", ovf0, 0);
    chk("max_cycle", cyc, 259);
    chk("max_wrap17_result", result1, 66303);
    chk("max_wrap17_ovf", ovf1, 1);
    consume();
    job(3, 0, cyc);
    chk("ovf17_result", result1, 64003);
    chk("ovf17_flag", ovf1, 1);
    chk("ovf17_wide_result", result0, 195075);
    consume();
    start = 1;
    len = 4;
    tick();
    start = 0;
    in_valid = 1;
    in_a = 1;
    in_b = 5;
    tick();
    in_a = 2;
    in_b = 6;
    tick();
    in_valid = 0;
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    chk("midrst_outputs", {in_ready0, res_valid0, ovf0, busy0, ma0, mb0}, 0);
    chk("midrst_result", result0, 0);
    ta[0] = 3;
    tbv[0] = 9;
    job(1, 0, cyc);
    chk("postrst_result", result0, 27);
    chk("postrst_cycle", cyc, 5);
    chk("postrst_ovf17_cleared", {ovf1, 17'(result1)}, {1'b0, 17'd27});
    consume();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
